data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data memory of the vector ASIP for alpha composition; sits on the execute/memory stage datapath.
- Holds a word-addressed 32-bit RAM. Supports scalar (1-word) and vector (4-word, 128-bit) access.
- Memory-maps a 32-bit GPIO output register and three colour-channel enable bits (R, G, B).
- Read is combinational; write is synchronous.

Parameters:
- DEPTH, 16384, number of 32-bit RAM words; valid word addresses are 0..DEPTH-1.
- GPIO_DATA_ADDR, 32'hFFFF_0000, word address of the GPIO data register.
- GPIO_CTRL_ADDR, 32'hFFFF_0004, word address of the GPIO enable register.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable, sampled on the rising clk edge.
- vf  in  1  vector flag: 1 = 4-word vector access, 0 = scalar access.
- addr  in  128  address; only addr[31:0] is used as the word address; bits [127:32] are ignored.
- wd  in  128  write data; scalar uses wd[31:0]; vector lane i = wd[32i+31:32i].
- rd  out  128  read data (combinational).
- GPIO  out  32  GPIO data register.
- GPIOEnR  out  1  red channel enable.
- GPIOEnG  out  1  green channel enable.
- GPIOEnB  out  1  blue channel enable.

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n=0: GPIO=0, GPIOEnR/G/B=0, and writes are blocked.
  - RAM contents are not affected by reset.
  - RAM initializes to all zeros at power-up.
- Let A = addr[31:0].
- Scalar read (vf=0):
  - A < DEPTH: rd = {96'b0, mem[A]}.
  - A = GPIO_DATA_ADDR: rd = {96'b0, GPIO}.
  - A = GPIO_CTRL_ADDR: rd = {125'b0, GPIOEnB, GPIOEnG, GPIOEnR}.
  - Any other A: rd = 0.
- Vector read (vf=1):
  - Lane i (i=0..3) reads mem[A+i] when A+i < DEPTH, otherwise 0.
  - Lane 0 drives rd[31:0].
  - GPIO registers are never visible in vector mode.
- rd updates combinationally with addr, vf and memory/register state (zero-cycle latency).
- Scalar write: on the rising clk edge with we=1, rst_n=1, vf=0.
  - A < DEPTH: mem[A] <= wd[31:0].
  - A = GPIO_DATA_ADDR: GPIO <= wd[31:0].
  - A = GPIO_CTRL_ADDR: GPIOEnR <= wd[0], GPIOEnG <= wd[1], GPIOEnB <= wd[2].
  - Any other A: no effect.
- Vector write: on the rising clk edge with we=1, vf=1.
  - mem[A+i] <= lane i for every A+i < DEPTH.
  - Lanes with A+i >= DEPTH are dropped; partial writes are allowed.
  - GPIO registers are never written in vector mode.
- A+i is computed in 32 bits. On wrap-around past 2^32-1 the lane is treated as out of range.
- Read-during-write, same address: rd shows the old value until the edge, then the new value.
- No alignment requirement on A for vector access.
- Reset asserted mid-write: reset wins and the GPIO registers clear. A RAM write in the same edge is suppressed.

Decomposition:
- Package data_memory_pkg:
  - WORD_W=32, LANES=4, DEPTH, GPIO_DATA_ADDR, GPIO_CTRL_ADDR.
  - Lane type: logic [WORD_W-1:0].
- One natural sub-module: gpio_regs, holding the GPIO data register, the enable register and the async reset.
- The RAM array and lane mux live in the top.

Test Plan:
- Reset then scalar write: assert rst_n=0, release; vf=0, A=0, wd=131, we=1, one edge -> rd=131. Then A=10000 -> rd=0 (power-up zero). Then A=0 -> rd=131.
- No-write check: we=0, A=10000, wd=65, one edge -> mem[10000] stays 0 and mem[0] stays 131.
- Vector write: vf=1, A=100, wd={32'd4,32'd3,32'd2,32'd1}, we=1, edge -> scalar reads of A=100..103 return 1,2,3,4. Vector read of A=100 returns the same 128-bit word.
- Vector boundary: vf=1, A=DEPTH-2, we=1, wd lanes 7,8,9,10 -> mem[DEPTH-2]=7, mem[DEPTH-1]=8, lanes 2..3 dropped. Vector read at the same A gives lanes 2..3 = 0.
- GPIO: scalar write GPIO_DATA_ADDR wd=32'hA5A5_0001 -> GPIO=32'hA5A5_0001. Write GPIO_CTRL_ADDR wd=5 -> EnR=1, EnG=0, EnB=1. Reads at both addresses return these values.
- Async reset: pull rst_n low between clock edges -> GPIO=0 and all enables 0 immediately; RAM word mem[0]=131 is preserved.

Source files
------------

// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared constants, lane type and lane address helpers for the data memory
package data_memory_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned BUS_W  = WORD_W * LANES;
  localparam int unsigned DEPTH  = 16384;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  localparam logic [31:0] GPIO_DATA_ADDR = 32'hFFFF_0000;
  localparam logic [31:0] GPIO_CTRL_ADDR = 32'hFFFF_0004;

  typedef logic [WORD_W-1:0] lane_t;

  // The 33-bit sum keeps the carry, so a lane that wraps past 2^32-1 compares as out of range.
  function automatic logic lane_in_range(input logic [31:0] a, input int unsigned i);
    logic [32:0] s;
    s = {1'b0, a} + 33'(i);
    return s < 33'(DEPTH);
  endfunction

  function automatic logic [MEM_AW-1:0] lane_index(input logic [31:0] a, input int unsigned i);
    return MEM_AW'(a + 32'(i));
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// rtl/data_memory_if.sv - execute-stage bus into the data memory plus its GPIO outputs
interface data_memory_if;
  import data_memory_pkg::*;

  logic             we;
  logic             vf;
  logic [BUS_W-1:0] addr;
  logic [BUS_W-1:0] wd;
  logic [BUS_W-1:0] rd;
  lane_t            GPIO;
  logic             GPIOEnR;
  logic             GPIOEnG;
  logic             GPIOEnB;

  modport master (
    output we, vf, addr, wd,
    input  rd, GPIO, GPIOEnR, GPIOEnG, GPIOEnB
  );

  modport slave (
    input  we, vf, addr, wd,
    output rd, GPIO, GPIOEnR, GPIOEnG, GPIOEnB
  );

endinterface

// File: rtl/data_memory_gpio_regs.sv
// rtl/data_memory_gpio_regs.sv - GPIO data and channel-enable registers with asynchronous clear
module data_memory_gpio_regs
  import data_memory_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_data_we,
  input  logic  i_ctrl_we,
  input  lane_t i_wd,
  output lane_t o_gpio,
  output logic  o_en_r,
  output logic  o_en_g,
  output logic  o_en_b
);

  lane_t r_gpio;
  logic  r_en_r;
  logic  r_en_g;
  logic  r_en_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio <= '0;
      r_en_r <= 1'b0;
      r_en_g <= 1'b0;
      r_en_b <= 1'b0;
    end else begin
      if (i_data_we) begin
        r_gpio <= i_wd;
      end
      if (i_ctrl_we) begin
        r_en_r <= i_wd[0];
        r_en_g <= i_wd[1];
        r_en_b <= i_wd[2];
      end
    end
  end

  assign o_gpio = r_gpio;
  assign o_en_r = r_en_r;
  assign o_en_g = r_en_g;
  assign o_en_b = r_en_b;

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word-addressed RAM with scalar/4-lane vector access and memory-mapped GPIO
module data_memory
  import data_memory_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  data_memory_if.slave bus
);

  // RAM is deliberately outside the reset domain; contents survive rst_n.
  lane_t r_mem [DEPTH] = '{default: '0};

  logic [31:0]       w_a;
  logic [LANES-1:0]  w_lane_ok;
  logic [MEM_AW-1:0] w_lane_idx [LANES];
  logic [BUS_W-1:0]  w_rd;
  lane_t             w_gpio;
  logic              w_en_r;
  logic              w_en_g;
  logic              w_en_b;
  logic              w_gpio_data_we;
  logic              w_gpio_ctrl_we;
  logic              w_unused_addr_hi;

  assign w_a              = bus.addr[31:0];
  assign w_unused_addr_hi = ^bus.addr[BUS_W-1:32];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_lane_ok[i]  = lane_in_range(w_a, i);
      w_lane_idx[i] = lane_index(w_a, i);
    end
  end

  always_comb begin
    w_rd = '0;
    if (bus.vf) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_lane_ok[i]) begin
          w_rd[WORD_W*i +: WORD_W] = r_mem[w_lane_idx[i]];
        end
      end
    end else if (w_lane_ok[0]) begin
      w_rd[WORD_W-1:0] = r_mem[w_lane_idx[0]];
    end else if (w_a == GPIO_DATA_ADDR) begin
      w_rd[WORD_W-1:0] = w_gpio;
    end else if (w_a == GPIO_CTRL_ADDR) begin
      w_rd[2:0] = {w_en_b, w_en_g, w_en_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && bus.we) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_lane_ok[i] && (bus.vf || i == 0)) begin
          r_mem[w_lane_idx[i]] <= bus.wd[WORD_W*i +: WORD_W];
        end
      end
    end
  end

  assign w_gpio_data_we = bus.we && !bus.vf && (w_a == GPIO_DATA_ADDR);
  assign w_gpio_ctrl_we = bus.we && !bus.vf && (w_a == GPIO_CTRL_ADDR);

  data_memory_gpio_regs u_gpio_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_data_we (w_gpio_data_we),
    .i_ctrl_we (w_gpio_ctrl_we),
    .i_wd      (bus.wd[WORD_W-1:0]),
    .o_gpio    (w_gpio),
    .o_en_r    (w_en_r),
    .o_en_g    (w_en_g),
    .o_en_b    (w_en_b)
  );

  assign bus.rd      = w_rd;
  assign bus.GPIO    = w_gpio;
  assign bus.GPIOEnR = w_en_r;
  assign bus.GPIOEnG = w_en_g;
  assign bus.GPIOEnB = w_en_b;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - table-driven scoreboard bench for the data memory
module tb_data_memory;
  import data_memory_pkg::*;

  typedef struct {
    string        name;
    logic         we;
    logic         vf;
    logic [127:0] addr;
    logic [127:0] wd;
    logic [127:0] exp_rd;
    logic [31:0]  exp_gpio;
    logic [2:0]   exp_en;
  } vec_t;

  typedef struct {
    string        name;
    logic [127:0] rd;
    logic [31:0]  gpio;
    logic [2:0]   en;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  data_memory_if bus ();

  data_memory dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] v4(input logic [31:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic add(input string n, input logic we, input logic vf, input logic [127:0] a,
                     input logic [127:0] wd, input logic [127:0] erd, input logic [31:0] eg,
                     input logic [2:0] ee);
    vecs.push_back('{n, we, vf, a, wd, erd, eg, ee});
  endtask

  task automatic check(input string n, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic expect_now(input string n, input logic [127:0] erd, input logic [31:0] eg,
                            input logic [2:0] ee);
    sb.push_back('{n, erd, eg, ee});
  endtask

  task automatic compare_top();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".rd"}, bus.rd, e.rd);
    check({e.name, ".gpio"}, {96'b0, bus.GPIO}, {96'b0, e.gpio});
    check({e.name, ".en"}, {125'b0, bus.GPIOEnB, bus.GPIOEnG, bus.GPIOEnR}, {125'b0, e.en});
  endtask

  task automatic drive(input logic we, input logic vf, input logic [127:0] a, input logic [127:0] wd);
    bus.we   = we;
    bus.vf   = vf;
    bus.addr = a;
    bus.wd   = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] gd;
    logic [127:0] gc;
    gd = {96'b0, GPIO_DATA_ADDR};
    gc = {96'b0, GPIO_CTRL_ADDR};

    add("wr0",       1, 0, 128'd0,     128'd131, 128'd131, 32'h0, 3'd0);
    add("rd10000",   0, 0, 128'd10000, 128'd0,   128'd0,   32'h0, 3'd0);
    add("rd0",       0, 0, 128'd0,     128'd0,   128'd131, 32'h0, 3'd0);
    add("nowr10000", 0, 0, 128'd10000, 128'd65,  128'd0,   32'h0, 3'd0);
    add("rd0b",      0, 0, 128'd0,     128'd65,  128'd131, 32'h0, 3'd0);
    add("vwr100",    1, 1, 128'd100,   v4(4, 3, 2, 1), v4(4, 3, 2, 1), 32'h0, 3'd0);
    add("rd100",     0, 0, 128'd100,   128'd0, 128'd1, 32'h0, 3'd0);
    add("rd101",     0, 0, 128'd101,   128'd0, 128'd2, 32'h0, 3'd0);
    add("rd102",     0, 0, 128'd102,   128'd0, 128'd3, 32'h0, 3'd0);
    add("rd103",     0, 0, 128'd103,   128'd0, 128'd4, 32'h0, 3'd0);
    add("vwr_edge",  1, 1, 128'(DEPTH - 2), v4(10, 9, 8, 7), v4(0, 0, 8, 7), 32'h0, 3'd0);
    add("rd_last",   0, 0, 128'(DEPTH - 1), 128'd0, 128'd8, 32'h0, 3'd0);
    add("rd_last2",  0, 0, 128'(DEPTH - 2), 128'd0, 128'd7, 32'h0, 3'd0);
    add("rd_oor",    0, 0, 128'(DEPTH),     128'd0, 128'd0, 32'h0, 3'd0);
    add("gpio_wr",   1, 0, gd, 128'hA5A5_0001, 128'hA5A5_0001, 32'hA5A5_0001, 3'd0);
    add("ctrl_wr",   1, 0, gc, 128'd5, 128'd5, 32'hA5A5_0001, 3'd5);
    add("gpio_rd",   0, 0, gd, 128'd0, 128'hA5A5_0001, 32'hA5A5_0001, 3'd5);
    add("vrd_gpio",  0, 1, gd, 128'd0, 128'd0, 32'hA5A5_0001, 3'd5);
    add("vwr_gpio",  1, 1, gd, {128{1'b1}}, 128'd0, 32'hA5A5_0001, 3'd5);
    add("gpio_keep", 0, 0, gd, 128'd0, 128'hA5A5_0001, 32'hA5A5_0001, 3'd5);
    add("vwr_wrap",  1, 1, 128'hFFFF_FFFE, v4(44, 33, 22, 11), 128'd0, 32'hA5A5_0001, 3'd5);
    add("wrap_rd0",  0, 0, 128'd0, 128'd0, 128'd131, 32'hA5A5_0001, 3'd5);
    add("wrap_rd1",  0, 0, 128'd1, 128'd0, 128'd0, 32'hA5A5_0001, 3'd5);
    add("wr_hole",   1, 0, 128'h8000_0000, 128'd9, 128'd0, 32'hA5A5_0001, 3'd5);
    add("wr_hiaddr", 1, 0, {96'hDEAD_BEEF_0123_4567_89AB_CDEF, 32'd5}, 128'd77, 128'd77, 32'hA5A5_0001, 3'd5);
    add("rd5",       0, 0, 128'd5, 128'd0, 128'd77, 32'hA5A5_0001, 3'd5);

    drive(0, 0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    expect_now("reset", 128'd0, 32'h0, 3'd0);
    compare_top();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].we, vecs[k].vf, vecs[k].addr, vecs[k].wd);
      expect_now(vecs[k].name, vecs[k].exp_rd, vecs[k].exp_gpio, vecs[k].exp_en);
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      compare_top();
    end

    // Read-during-write: old value visible before the edge, new value after.
    @(negedge clk);
    drive(1, 0, 128'd7, 128'd55);
    #1;
    expect_now("rdw_before", 128'd0, 32'hA5A5_0001, 3'd5);
    compare_top();
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    expect_now("rdw_after", 128'd55, 32'hA5A5_0001, 3'd5);
    compare_top();

    // Asynchronous reset between edges, then writes attempted while held in reset.
    @(negedge clk);
    drive(0, 0, 128'd0, 128'd0);
    #2 rst_n = 1'b0;
    #1;
    expect_now("async_rst", 128'd131, 32'h0, 3'd0);
    compare_top();
    drive(1, 0, 128'd0, 128'd999);
    @(posedge clk);
    #1;
    expect_now("rst_ramwr", 128'd131, 32'h0, 3'd0);
    compare_top();
    @(negedge clk);
    drive(1, 0, gd, 128'h1234_5678);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
    expect_now("rst_gpiowr", 128'd0, 32'h0, 3'd0);
    compare_top();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 128'd100, 128'd0);
    #1;
    expect_now("post_rst_v", v4(4, 3, 2, 1), 32'h0, 3'd0);
    compare_top();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
